ram_arbiter: RTL

//  Round-robin arbiter sharing the single-port 8-bit program/data RAM between NUM_REQ requesters
//  (CPU fetch, CPU load/store, program loader). Drives the RAM port (clock, wren, address, data, q)

---
 rtl/ram_arbiter_pkg.sv | 9 +
 rtl/ram_arbiter_if.sv | 19 +
 rtl/ram_arbiter_rr_pick.sv | 26 ++
 rtl/ram_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter: bus widths and FSM state encoding.
package mem_arb_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic {FREE = 1'b0, LOCKED = 1'b1} arb_state_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter; one lane per requester.
interface ram_arbiter_if import mem_arb_pkg::*; #(
  parameter int NUM_REQ = 2
) ();
  logic  [NUM_REQ-1:0] req;
  logic  [NUM_REQ-1:0] we;
  addr_t [NUM_REQ-1:0] addr;
  data_t [NUM_REQ-1:0] wdata;
  logic  [NUM_REQ-1:0] lock;
  logic  [NUM_REQ-1:0] gnt;
  logic  [NUM_REQ-1:0] rvalid;
  data_t               rdata;
  logic                lock_err;

  modport slave  (input  req, we, addr, wdata, lock,
                  output gnt, rvalid, rdata, lock_err);
  modport master (output req, we, addr, wdata, lock,
                  input  gnt, rvalid, rdata, lock_err);
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);
  logic found;

  // Scan from ptr upward; the first hit wins, idx stays 0 when nothing requests.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
        found = 1'b1;
        gnt_o[(int'(ptr_i) + k) % NUM_REQ] = 1'b1;
        idx_o = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for the single-port program/data RAM with locked
// multi-beat ownership and a watchdog on lock length.
module ram_arbiter import mem_arb_pkg::*; #(
  parameter int NUM_REQ  = 2,
  parameter int MAX_LOCK = 16
) (
  input  logic           clock,
  input  logic           reset_n,
  ram_arbiter_if.slave   bus,
  output logic           ram_wren,
  output addr_t          ram_address,
  output data_t          ram_data,
  input  data_t          ram_q
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK);

  arb_state_t          state_q;
  logic [IDX_W-1:0]    ptr_q, owner_q;
  logic [CNT_W-1:0]    lock_cnt_q;
  logic [NUM_REQ-1:0]  rvalid_q;
  logic                lock_err_q;

  logic [NUM_REQ-1:0]  pick_gnt, gnt;
  logic [IDX_W-1:0]    pick_idx, g, nxt_ptr;
  logic                acc;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  // Grant: picker in FREE, owner only in LOCKED; nothing while held in reset.
  always_comb begin
    gnt = '0;
    g   = pick_idx;
    if (!reset_n) begin
      gnt = '0;
    end else if (state_q == FREE) begin
      gnt = pick_gnt;
    end else begin
      g = owner_q;
      gnt[owner_q] = bus.req[owner_q];
    end
  end

  assign acc     = |(bus.req & gnt);
  assign nxt_ptr = IDX_W'((int'(g) + 1) % NUM_REQ);

  // RAM port follows the granted lane; idle cycles park on lane 0 with wren low.
  assign ram_address = acc ? bus.addr[g]  : bus.addr[0];
  assign ram_data    = acc ? bus.wdata[g] : bus.wdata[0];
  assign ram_wren    = acc & bus.we[g];

  assign bus.gnt      = gnt;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = ram_q;
  assign bus.lock_err = lock_err_q;

  // Arbitration FSM plus read-return valid and watchdog pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FREE;
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
      lock_err_q <= 1'b0;
    end else begin
      rvalid_q   <= '0;
      lock_err_q <= 1'b0;
      if (acc && !bus.we[g]) rvalid_q[g] <= 1'b1;
      if (acc) begin
        case (state_q)
          FREE: begin
            if (bus.lock[g]) begin
              state_q    <= LOCKED;
              owner_q    <= g;
              lock_cnt_q <= CNT_W'(1);
            end else begin
              ptr_q <= nxt_ptr;
            end
          end
          LOCKED: begin
            if (bus.lock[g] && lock_cnt_q != CNT_W'(MAX_LOCK - 1)) begin
              lock_cnt_q <= lock_cnt_q + CNT_W'(1);
            end else begin
              // Voluntary release, or watchdog forcing one after the last allowed beat.
              state_q    <= FREE;
              ptr_q      <= nxt_ptr;
              lock_cnt_q <= '0;
              lock_err_q <= bus.lock[g];
            end
          end
          default: state_q <= FREE;
        endcase
      end
    end
  end
endmodule
